// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus transmitter: FSM states, line levels
// and the frame-length calculation used to size the shift register.
package serial_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Line levels: the bus idles high, a frame opens with a dominant 0
   localparam logic SOF_BIT   = 1'b0;
   localparam logic EOF_BIT   = 1'b1;
   localparam logic RECESSIVE = 1'b1;

   // SOF + src addr + dest addr + data + CRC + EOF
   function automatic int frame_len(input int addr_w, input int data_w, input int crc_w);
      return 2 + 2 * addr_w + data_w + crc_w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority select: the lowest requesting index at or above ptr
// wins; if none is at or above ptr, the lowest requesting index overall wins.
// Purely combinational; the pointer register belongs to the parent.
module rr_arbiter #(
   parameter int N     = 16,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [N-1:0] at_or_above;
   logic [N-1:0] upper_req;
   logic [N-1:0] cand;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign at_or_above[gi] = (gi >= int'(ptr));
      end
   endgenerate

   // Requests in the upper window take precedence; otherwise wrap to index 0
   assign upper_req = req & at_or_above;
   assign cand      = (|upper_req) ? upper_req : req;
   assign valid     = |req;

   // Pick the lowest set bit of the candidate vector and encode it
   always_comb begin
      idx   = '0;
      grant = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) begin
            idx = IDX_W'(i);
         end
      end
      if (valid) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/serial_bus_tx_arbiter.sv
// Multi-node serial bus transmitter: arbitrates round-robin among N_NODES
// senders, captures the winner's fields into a shift register and drives the
// frame MSB-first onto bus_out, followed by a programmable recessive gap.
module serial_bus_tx_arbiter
   import serial_bus_pkg::*;
#(
   parameter int N_NODES  = 16,
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 4,
   parameter int CRC_W    = 4,
   parameter int IDLE_GAP = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [N_NODES-1:0]      req,
   input  logic [N_NODES*DATA_W-1:0] data_flat,
   input  logic [N_NODES*ADDR_W-1:0] dest_flat,
   input  logic [N_NODES*CRC_W-1:0]  crc_flat,
   output logic [N_NODES-1:0]      ack,
   output logic [N_NODES-1:0]      done,
   output logic [N_NODES-1:0]      grant,
   output logic                    busy,
   output logic                    bus_out,
   output logic [15:0]             frame_cnt
);

   localparam int L          = frame_len(ADDR_W, DATA_W, CRC_W);
   localparam int CNT_W      = $clog2(L + 1);
   localparam int IDX_W      = (N_NODES > 1) ? $clog2(N_NODES) : 1;
   localparam int GAP_W      = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
   localparam int GAP_LOAD_I = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LOAD_I);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [L-1:0]         shift_q, shift_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic                 bus_out_q, bus_out_d;
   logic                 busy_q, busy_d;
   logic [N_NODES-1:0]   grant_q, grant_d;
   logic [N_NODES-1:0]   ack_q, ack_d;
   logic [N_NODES-1:0]   done_q, done_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;

   logic [N_NODES-1:0]   win_grant;
   logic [IDX_W-1:0]     win_idx;
   logic                 win_valid;

   logic [DATA_W-1:0]    data_arr [N_NODES];
   logic [ADDR_W-1:0]    dest_arr [N_NODES];
   logic [CRC_W-1:0]     crc_arr  [N_NODES];
   logic [L-1:0]         frame;
   logic                 last_bit;

   generate
      for (genvar gi = 0; gi < N_NODES; gi++) begin : g_fields
         assign data_arr[gi] = data_flat[gi*DATA_W +: DATA_W];
         assign dest_arr[gi] = dest_flat[gi*ADDR_W +: ADDR_W];
         assign crc_arr[gi]  = crc_flat[gi*CRC_W +: CRC_W];
      end
   endgenerate

   rr_arbiter #(
      .N     (N_NODES),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req   (req),
      .ptr   (ptr_q),
      .grant (win_grant),
      .idx   (win_idx),
      .valid (win_valid)
   );

   // The source address is simply the winning node index
   assign frame = {SOF_BIT, ADDR_W'(win_idx), dest_arr[win_idx],
                   data_arr[win_idx], crc_arr[win_idx], EOF_BIT};

   // bit_cnt counts bits already placed on the line, so L means EOF is out
   assign last_bit = (bit_cnt_q == CNT_W'(L));

   // State and output registers; reset abandons any frame in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         shift_q     <= '1;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         bus_out_q   <= RECESSIVE;
         busy_q      <= 1'b0;
         grant_q     <= '0;
         ack_q       <= '0;
         done_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         bus_out_q   <= bus_out_d;
         busy_q      <= busy_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Next-state logic: IDLE arbitrates, SEND runs L bits, GAP holds the line
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (win_valid) state_d = SEND;
         SEND: if (last_bit) state_d = (IDLE_GAP == 0) ? IDLE : GAP;
         GAP:  if (gap_cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output values for each state
   always_comb begin
      ptr_d       = ptr_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      bus_out_d   = RECESSIVE;
      busy_d      = busy_q;
      grant_d     = grant_q;
      ack_d       = '0;
      done_d      = '0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         IDLE: begin
            busy_d  = 1'b0;
            grant_d = '0;
            if (win_valid) begin
               // SOF goes straight out; the remaining bits wait in the shifter
               bus_out_d = frame[L-1];
               shift_d   = {frame[L-2:0], RECESSIVE};
               bit_cnt_d = CNT_W'(1);
               grant_d   = win_grant;
               ack_d     = win_grant;
               busy_d    = 1'b1;
               ptr_d     = (win_idx == IDX_W'(N_NODES - 1)) ? '0 : win_idx + IDX_W'(1);
            end
         end
         SEND: begin
            if (last_bit) begin
               done_d      = grant_q;
               grant_d     = '0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               busy_d      = (IDLE_GAP != 0);
               gap_cnt_d   = GAP_LOAD;
            end else begin
               bus_out_d = shift_q[L-1];
               shift_d   = {shift_q[L-2:0], RECESSIVE};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               busy_d = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            grant_d = '0;
         end
      endcase
   end

   assign ack       = ack_q;
   assign done      = done_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign bus_out   = bus_out_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_bus_tx_arbiter.sv
// Bench for serial_bus_tx_arbiter: a default 16-node instance and a small
// 4-node / zero-gap instance share clock and reset. Expected frames, winners
// and counts come from a frame-level model held in this file.
module tb_serial_bus_tx_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [15:0] req_a;
   logic [3:0]  req_b;

   logic [63:0] data_m [16];
   logic [3:0]  dest_m [16];
   logic [3:0]  crc_m  [16];

   logic [16*64-1:0] data_flat_a;
   logic [16*4-1:0]  dest_flat_a;
   logic [16*4-1:0]  crc_flat_a;
   logic [4*8-1:0]   data_flat_b;
   logic [4*2-1:0]   dest_flat_b;
   logic [4*4-1:0]   crc_flat_b;

   // Pack per-node fields into the flat buses of both instances
   always_comb begin
      data_flat_a = '0;
      dest_flat_a = '0;
      crc_flat_a  = '0;
      data_flat_b = '0;
      dest_flat_b = '0;
      crc_flat_b  = '0;
      for (int i = 0; i < 16; i++) begin
         data_flat_a[i*64 +: 64] = data_m[i];
         dest_flat_a[i*4 +: 4]   = dest_m[i];
         crc_flat_a[i*4 +: 4]    = crc_m[i];
      end
      for (int i = 0; i < 4; i++) begin
         data_flat_b[i*8 +: 8] = data_m[i][7:0];
         dest_flat_b[i*2 +: 2] = dest_m[i][1:0];
         crc_flat_b[i*4 +: 4]  = crc_m[i];
      end
   end

   logic [15:0] a_ack, a_done, a_grant, a_cnt;
   logic        a_busy, a_bus;
   logic [3:0]  b_ack, b_done, b_grant;
   logic [15:0] b_cnt;
   logic        b_busy, b_bus;

   serial_bus_tx_arbiter dut_a (
      .clock     (clock),
      .reset     (reset),
      .req       (req_a),
      .data_flat (data_flat_a),
      .dest_flat (dest_flat_a),
      .crc_flat  (crc_flat_a),
      .ack       (a_ack),
      .done      (a_done),
      .grant     (a_grant),
      .busy      (a_busy),
      .bus_out   (a_bus),
      .frame_cnt (a_cnt)
   );

   serial_bus_tx_arbiter #(
      .N_NODES  (4),
      .DATA_W   (8),
      .ADDR_W   (2),
      .CRC_W    (4),
      .IDLE_GAP (0)
   ) dut_b (
      .clock     (clock),
      .reset     (reset),
      .req       (req_b),
      .data_flat (data_flat_b),
      .dest_flat (dest_flat_b),
      .crc_flat  (crc_flat_b),
      .ack       (b_ack),
      .done      (b_done),
      .grant     (b_grant),
      .busy      (b_busy),
      .bus_out   (b_bus),
      .frame_cnt (b_cnt)
   );

   // sel chooses which instance the shared check tasks observe and drive
   int          sel;
   logic [15:0] m_ack, m_done, m_grant, m_cnt;
   logic        m_busy, m_bus;

   always_comb begin
      m_ack   = '0;
      m_done  = '0;
      m_grant = '0;
      m_cnt   = '0;
      m_busy  = 1'b0;
      m_bus   = 1'b0;
      if (sel == 0) begin
         m_ack = a_ack; m_done = a_done; m_grant = a_grant;
         m_cnt = a_cnt; m_busy = a_busy; m_bus = a_bus;
      end else begin
         m_ack = {12'h000, b_ack}; m_done = {12'h000, b_done};
         m_grant = {12'h000, b_grant};
         m_cnt = b_cnt; m_busy = b_busy; m_bus = b_bus;
      end
   end

   int          n_assert = 0;
   int          n_fail   = 0;
   int          ptr_m [2];
   logic [15:0] cnt_m [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester at or after the pointer, else first overall
   function automatic int model_winner(input logic [15:0] r, input int nn, input int p);
      for (int i = p; i < nn; i++) if (r[i]) return i;
      for (int i = 0; i < nn; i++) if (r[i]) return i;
      return -1;
   endfunction

   task automatic set_req(input logic [15:0] r);
      if (sel == 0) req_a = r;
      else          req_b = r[3:0];
   endtask

   task automatic shuffle_fields();
      for (int i = 0; i < 16; i++) begin
         data_m[i] = {$urandom, $urandom};
         dest_m[i] = 4'($urandom);
         crc_m[i]  = 4'($urandom);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_bus"},   m_bus,   1);
      chk({tag, "_busy"},  m_busy,  0);
      chk({tag, "_grant"}, m_grant, 0);
      chk({tag, "_ack"},   m_ack,   0);
      chk({tag, "_done"},  m_done,  0);
   endtask

   // Called at a negedge while the selected instance is in IDLE; drives req,
   // follows the whole frame and gap, and returns in the next IDLE cycle.
   task automatic run_frame(input logic [15:0] r, input int drop_node);
      int nn, aw, dw, len, gap, win;
      bit exp_q[$];
      logic [15:0] onehot;
      logic [15:0] t;
      nn  = (sel == 0) ? 16 : 4;
      aw  = (sel == 0) ? 4 : 2;
      dw  = (sel == 0) ? 64 : 8;
      gap = (sel == 0) ? 2 : 0;
      len = 2 + 2 * aw + dw + 4;
      win = model_winner(r, nn, ptr_m[sel]);
      onehot = '0;
      onehot[win] = 1'b1;
      exp_q = {};
      exp_q.push_back(1'b0);
      for (int b = aw - 1; b >= 0; b--) exp_q.push_back(win[b]);
      for (int b = aw - 1; b >= 0; b--) exp_q.push_back(dest_m[win][b]);
      for (int b = dw - 1; b >= 0; b--) exp_q.push_back(data_m[win][b]);
      for (int b = 3; b >= 0; b--)      exp_q.push_back(crc_m[win][b]);
      exp_q.push_back(1'b1);

      set_req(r);
      @(negedge clock);
      chk("ack", m_ack, onehot);
      chk("busy_start", m_busy, 1);
      for (int k = 0; k < len; k++) begin
         if (k > 0) @(negedge clock);
         chk("bus_bit", m_bus, exp_q[k]);
         chk("grant", m_grant, onehot);
         if (k == 1) chk("ack_pulse", m_ack, 0);
         if (k == len - 1) chk("done_early", m_done, 0);
         if (k == 5) set_req(16'($urandom));
         if (k == 10 && drop_node >= 0) begin
            t = r;
            t[drop_node] = 1'b0;
            set_req(t);
         end
      end
      @(negedge clock);
      ptr_m[sel] = (win + 1) % nn;
      cnt_m[sel] = cnt_m[sel] + 16'd1;
      chk("done", m_done, onehot);
      chk("frame_cnt", m_cnt, cnt_m[sel]);
      chk("grant_clear", m_grant, 0);
      chk("bus_after", m_bus, 1);
      chk("busy_after", m_busy, (gap > 0));
      for (int j = 1; j <= gap; j++) begin
         @(negedge clock);
         chk("done_clear", m_done, 0);
         chk("bus_gap", m_bus, 1);
         chk("busy_gap", m_busy, (j < gap));
      end
      $display("frame dut=%0d req=%04h node=%0d frames=%0d", sel, r, win, cnt_m[sel]);
      set_req(16'h0000);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      sel      = 0;
      reset    = 1'b1;
      req_a    = '0;
      req_b    = '0;
      ptr_m[0] = 0;
      ptr_m[1] = 0;
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      shuffle_fields();
      repeat (3) @(negedge clock);

      // Reset values on both instances
      check_idle_outputs("rst_a");
      chk("rst_a_cnt", m_cnt, 0);
      sel = 1;
      check_idle_outputs("rst_b");
      chk("rst_b_cnt", m_cnt, 0);
      sel = 0;
      reset = 1'b0;
      @(negedge clock);

      // Reset at bit 30 of a node5 frame abandons it
      set_req(16'h0020);
      @(negedge clock);
      chk("midrst_ack", m_ack, 16'h0020);
      repeat (30) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_idle_outputs("midrst");
      chk("midrst_cnt", m_cnt, 0);
      set_req(16'h0000);
      repeat (2) @(negedge clock);
      chk("midrst_done", m_done, 0);
      reset = 1'b0;
      @(negedge clock);
      $display("reset mid-frame dut=0 frames=%0d", m_cnt);

      // After reset the pointer is back at 0: node0 beats node7
      run_frame(16'h0081, -1);

      // Single sender with unit fields
      data_m[0] = 64'd1;
      dest_m[0] = 4'd1;
      crc_m[0]  = 4'd1;
      run_frame(16'h0001, -1);

      // Contention between nodes 1 and 2, request held
      repeat (3) run_frame(16'h0006, -1);

      // Pointer wrap: node14 leaves ptr=15, then 15 wins before 0
      run_frame(16'h4000, -1);
      run_frame(16'h8001, -1);
      run_frame(16'h8001, -1);

      // Request dropped mid-frame still completes
      run_frame(16'h0008, 3);

      // Random traffic on the default instance
      repeat (20) begin
         shuffle_fields();
         r = 16'($urandom);
         if (r == 16'h0000) r = 16'h0001;
         run_frame(r, -1);
      end

      // Small instance with no gap: back-to-back frames
      sel = 1;
      @(negedge clock);
      repeat (15) begin
         shuffle_fields();
         r = {12'h000, 4'($urandom)};
         if (r == 16'h0000) r = 16'h0004;
         run_frame(r, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_bus_tx_arbiter.md
# serial_bus_tx_arbiter

Multi-node serial bus transmitter that arbitrates among N_NODES local senders and serialises the winning node's frame onto a single shared line. Each frame carries the sender address, receiver address, data word and CRC nibble. It sits between the per-node message registers and the `bus_out` pin of the top-level bus model. It generalises the fixed 16-node / 64-bit transmitter with:
- parametrised widths;
- per-node request/acknowledge handshakes;
- round-robin fairness;
- a programmable inter-frame gap.

## Interface
- `N_NODES`, 16, number of sender nodes (≥2)
- `DATA_W`, 64, payload bits per frame
- `ADDR_W`, 4, address field width; must satisfy 2^ADDR_W ≥ N_NODES
- `CRC_W`, 4, CRC field width (CRC supplied by node, not computed here)
- `IDLE_GAP`, 2, recessive cycles forced after each frame (0 allowed)

Ports:
- `clock` in 1: single clock; all logic rising-edge
- `reset` in 1: synchronous, active-high
- `req` in N_NODES: node i wants to send; level, sampled only in IDLE
- `data_flat` in N_NODES*DATA_W: node i payload at [i*DATA_W +: DATA_W]
- `dest_flat` in N_NODES*ADDR_W: node i receiver address
- `crc_flat` in N_NODES*CRC_W: node i CRC
- `ack` out N_NODES: one-cycle pulse; node's fields have been captured
- `done` out N_NODES: one-cycle pulse; node's frame fully sent
- `grant` out N_NODES: one-hot owner of the bus during a frame, else 0
- `busy` out 1: high from frame start through end of gap
- `bus_out` out 1: serial line, idle/recessive = 1
- `frame_cnt` out 16: frames completed since reset, wraps at 2^16

## Operation
- Frame, MSB-first per field: SOF (0), src addr (ADDR_W, the granted index), dest addr (ADDR_W), data (DATA_W), CRC (CRC_W), EOF (1). Length L = 2 + 2*ADDR_W + DATA_W + CRC_W (78 at defaults).
- States:
  - IDLE → SEND when `|req`.
  - SEND → GAP after the EOF bit; SEND → IDLE directly if IDLE_GAP=0.
  - GAP → IDLE after IDLE_GAP cycles.
- On the IDLE→SEND edge:
  - load the full frame into a shift register of length L;
  - set `grant`;
  - pulse `ack` for the granted node.
- Arbitration: round-robin. Pointer `ptr` starts at 0 after reset. The winner is the lowest index ≥ `ptr` with `req` high, wrapping to 0. After a grant, `ptr` = winner+1 mod N_NODES.
- `req` changes during SEND/GAP are ignored; deasserting `req` does not abort a frame. A node that holds `req` after `ack` gets another frame when next selected. Fields are read only at capture.
- dest = src is legal and is transmitted unchanged.

## Timing
- Reset values: `bus_out`=1, `busy`=0, `grant`=0, `ack`=0, `done`=0, `frame_cnt`=0, `ptr`=0, state IDLE.
- `req[i]` high before edge E in IDLE:
  - after E: `ack[i]`=1 for one cycle, `grant[i]`=1, `busy`=1, `bus_out`=SOF=0.
  - bit k of the frame is driven in cycle E+k; EOF is driven in cycle E+L-1.
- After edge E+L:
  - `done[i]` pulses for one cycle;
  - `frame_cnt` increments;
  - `grant` clears;
  - `bus_out`=1 for IDLE_GAP cycles, then IDLE.
- `busy` falls with entry to IDLE. The earliest next SOF is at edge E+L+IDLE_GAP+1 (one IDLE cycle to arbitrate).
- With IDLE_GAP=0, `done` coincides with the IDLE cycle.
- Reset mid-frame or mid-gap:
  - next cycle, all outputs return to reset values;
  - no `done` pulse; the partial frame is abandoned.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `serial_bus_pkg`:
  - state enum (IDLE, SEND, GAP);
  - SOF/EOF/recessive level constants;
  - a frame-length function of the parameters.
- One sub-module, `rr_arbiter`: parametrised round-robin priority select.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot grant and winner index.
  - Combinational; `ptr` register lives in the parent.
- Shift register, bit counter (width clog2(L+1)) and gap counter live in the top.

## Test plan
- Single sender:
  - Stimulus: node0, data=1, dest=1, crc=1, `req`=0x0001.
  - Response: `ack[0]` at E+1.
  - `bus_out` sequence: 0, 0000, 0001, 63×0 then 1, 0001, 1.
  - `done[0]` at E+78, `frame_cnt`=1.
- Contention:
  - Stimulus: `req`=0x0006 held.
  - Response: frames from node1 then node2, then node1 again.
  - Gap of exactly 2 recessive cycles plus 1 IDLE cycle between frames.
- Wrap fairness:
  - Stimulus: `ptr`=15 after a node14 frame, then `req`=0x8001.
  - Response: node15 wins first, then node0.
- Request drop:
  - Stimulus: deassert `req[3]` 10 cycles into its frame.
  - Response: frame completes with all 78 bits and `done[3]` pulses.
- Reset mid-frame:
  - Stimulus: `reset` at bit 30.
  - Response: next cycle `bus_out`=1, `grant`=0, no `done`, `frame_cnt` unchanged at 0.
  - A new `req` restarts from node0 priority.
- Parameter sweep:
  - Stimulus: N_NODES=4, DATA_W=8, ADDR_W=2, CRC_W=4, IDLE_GAP=0.
  - Response: L=18; back-to-back frames with one IDLE cycle between them; `frame_cnt` matches the number of `done` pulses.
